// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and word widths for the HI/LO multiply/accumulate unit.
package mdu_pkg;

  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_MADD  = 3'd2,
    MDU_MSUB  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_WB   = 2'd3
  } mdu_state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct read as unsigned.
  function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v, input logic sgn);
    return (sgn && v[WORD_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_shift_add_core.sv
// One shift-add step: adds multiplicand x low multiplier digit into the partial product,
// then advances multiplicand and multiplier by BITS_PER_CYCLE. Purely combinational.
module mdu_shift_add_core
  import mdu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [DWORD_W-1:0] partial_i,
  input  logic [DWORD_W-1:0] mcand_i,
  input  logic [WORD_W-1:0]  mplier_i,
  output logic [DWORD_W-1:0] partial_o,
  output logic [DWORD_W-1:0] mcand_o,
  output logic [WORD_W-1:0]  mplier_o
);

  always_comb begin
    partial_o = partial_i;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      if (mplier_i[b]) partial_o = partial_o + (mcand_i << b);
    end
  end

  assign mcand_o  = mcand_i << BITS_PER_CYCLE;
  assign mplier_o = mplier_i >> BITS_PER_CYCLE;

endmodule

// File: rtl/hilo_mdu_sequencer.sv
// Multi-cycle mult/multu/madd/msub/mthi/mtlo unit owning HI/LO, stalling dependent accesses.
// Define HILO_MDU_EARLY_TERM_EN to finish iterating as soon as the remaining multiplier is zero.
module hilo_mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2,
  parameter int ITER_W         = 6
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              Start_i,
  input  logic [2:0]        MduOp_i,
  input  logic [WORD_W-1:0] OpA_i,
  input  logic [WORD_W-1:0] OpB_i,
  input  logic              HiLoRead_i,
  input  logic              Flush_i,
  output logic              Busy_o,
  output logic              Done_o,
  output logic              Stall_o,
  output logic [WORD_W-1:0] HI_o,
  output logic [WORD_W-1:0] LO_o
);

  localparam logic [ITER_W-1:0] ITERS = ITER_W'(WORD_W / BITS_PER_CYCLE);

  mdu_state_e          state_q, state_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [DWORD_W-1:0]  mcand_q, mcand_d;
  logic [WORD_W-1:0]   mplier_q, mplier_d;
  logic [DWORD_W-1:0]  partial_q, partial_d;
  logic [DWORD_W-1:0]  res_q, res_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic                done_q, done_d;
  logic [WORD_W-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [DWORD_W-1:0]  core_partial, core_mcand, product;
  logic [WORD_W-1:0]   core_mplier;
  logic                sgn;

  mdu_shift_add_core #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_core (
    .partial_i (partial_q),
    .mcand_i   (mcand_q),
    .mplier_i  (mplier_q),
    .partial_o (core_partial),
    .mcand_o   (core_mcand),
    .mplier_o  (core_mplier)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    res_d     = res_q;
    op_d      = op_q;
    neg_d     = neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    product   = '0;
    sgn       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start_i && !Flush_i) begin
          case (MduOp_i)
            MDU_MTHI: begin
              hi_d   = OpA_i;
              done_d = 1'b1;
            end
            MDU_MTLO: begin
              lo_d   = OpA_i;
              done_d = 1'b1;
            end
            MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MSUB: begin
              sgn       = is_signed_op(MduOp_i);
              mcand_d   = {{WORD_W{1'b0}}, magnitude(OpA_i, sgn)};
              mplier_d  = magnitude(OpB_i, sgn);
              partial_d = '0;
              neg_d     = sgn & (OpA_i[WORD_W-1] ^ OpB_i[WORD_W-1]);
              op_d      = MduOp_i;
              cnt_d     = ITERS;
              state_d   = S_ITER;
`ifdef HILO_MDU_EARLY_TERM_EN
              if (mplier_d == '0) state_d = S_FIX;
`endif
            end
            default: ;
          endcase
        end
      end
      S_ITER: begin
        if (Flush_i) begin
          state_d = S_IDLE;
        end else begin
          partial_d = core_partial;
          mcand_d   = core_mcand;
          mplier_d  = core_mplier;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == ITER_W'(1)) state_d = S_FIX;
`ifdef HILO_MDU_EARLY_TERM_EN
          if (core_mplier == '0) state_d = S_FIX;
`endif
        end
      end
      S_FIX: begin
        if (Flush_i) begin
          state_d = S_IDLE;
        end else begin
          product = neg_q ? (~partial_q + 1'b1) : partial_q;
          case (op_q)
            MDU_MADD: res_d = {hi_q, lo_q} + product;
            MDU_MSUB: res_d = {hi_q, lo_q} - product;
            default:  res_d = product;
          endcase
          state_d = S_WB;
        end
      end
      // Commit is past the point of no return, so a late flush is ignored here.
      S_WB: begin
        hi_d    = res_q[DWORD_W-1:WORD_W];
        lo_d    = res_q[WORD_W-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      res_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      res_q     <= res_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy_o  = (state_q != S_IDLE);
  assign Stall_o = Busy_o & (Start_i | HiLoRead_i);
  assign Done_o  = done_q;
  assign HI_o    = hi_q;
  assign LO_o    = lo_q;

endmodule
